// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the AXI interrupt controller: register offsets,
// AXI response codes, FSM state encodings and the byte-strobe helper.
package irq_ctrl_pkg;

    localparam logic [2:0] REG_ISR  = 3'd0;
    localparam logic [2:0] REG_IER  = 3'd1;
    localparam logic [2:0] REG_IPR  = 3'd2;
    localparam logic [2:0] REG_MODE = 3'd3;
    localparam logic [2:0] REG_SIE  = 3'd4;
    localparam logic [2:0] REG_CIE  = 3'd5;
    localparam logic [2:0] REG_IVR  = 3'd6;
    localparam logic [2:0] REG_MER  = 3'd7;

    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_WAIT  = 2'd1,
        W_BURST = 2'd2,
        W_RESP  = 2'd3
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/irq_ctrl_core.sv
// Interrupt storage and aggregation: source sampling, ISR/IER/MODE/MER,
// lowest-index vector encoder and the registered CPU interrupt.
module irq_ctrl_core
    import irq_ctrl_pkg::*;
#(
    parameter int                 NUM_IRQ      = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_DEFAULT = NUM_IRQ'(8'h01)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_wr_en,
    input  logic [2:0]         i_wr_idx,
    input  logic [31:0]        i_wr_data,
    input  logic [3:0]         i_wr_strb,
    input  logic [2:0]         i_rd_idx,
    output logic [31:0]        o_rd_data,
    output logic               o_irq
);

    localparam logic [NUM_IRQ-1:0] ZERO = {NUM_IRQ{1'b0}};

    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_isr;
    logic [NUM_IRQ-1:0] r_ier;
    logic [NUM_IRQ-1:0] r_mode;
    logic               r_mer;
    logic               r_irq;

    logic [31:0]        w_bmask32;
    logic [31:0]        w_wm32;
    logic [NUM_IRQ-1:0] w_bmask;
    logic [NUM_IRQ-1:0] w_bits;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_ipr;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_ier_nxt;
    logic [NUM_IRQ-1:0] w_mode_nxt;
    logic               w_mer_nxt;
    logic [31:0]        w_ivr;
    logic [31:0]        w_rd;
    logic               w_unused;

    assign w_bmask32 = strb_to_mask(i_wr_strb);
    assign w_wm32    = i_wr_data & w_bmask32;
    assign w_bmask   = w_bmask32[NUM_IRQ-1:0];
    assign w_bits    = w_wm32[NUM_IRQ-1:0];
    assign w_unused  = ^{w_bmask32, w_wm32};

    // Edge sources pend on a rising transition, level sources while high.
    assign w_set = (i_irq & ~r_irq_q & r_mode) | (i_irq & ~r_mode);
    assign w_ipr = r_isr & r_ier;

    // Register write decode; untouched registers hold their value.
    always_comb begin
        w_w1c      = ZERO;
        w_ier_nxt  = r_ier;
        w_mode_nxt = r_mode;
        w_mer_nxt  = r_mer;
        if (i_wr_en) begin
            case (i_wr_idx)
                REG_ISR:  w_w1c      = w_bits;
                REG_IER:  w_ier_nxt  = (r_ier & ~w_bmask) | w_bits;
                REG_MODE: w_mode_nxt = (r_mode & ~w_bmask) | w_bits;
                REG_SIE:  w_ier_nxt  = r_ier | w_bits;
                REG_CIE:  w_ier_nxt  = r_ier & ~w_bits;
                REG_MER:  w_mer_nxt  = i_wr_strb[0] ? i_wr_data[0] : r_mer;
                default:  w_w1c      = ZERO;
            endcase
        end else begin
            w_w1c = ZERO;
        end
    end

    // Lowest pending-and-enabled index wins; all-ones when nothing is pending.
    always_comb begin
        w_ivr = 32'hFFFF_FFFF;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            w_ivr = w_ipr[i] ? 32'(i) : w_ivr;
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        w_rd = 32'h0000_0000;
        case (i_rd_idx)
            REG_ISR:  w_rd[NUM_IRQ-1:0] = r_isr;
            REG_IER:  w_rd[NUM_IRQ-1:0] = r_ier;
            REG_IPR:  w_rd[NUM_IRQ-1:0] = w_ipr;
            REG_MODE: w_rd[NUM_IRQ-1:0] = r_mode;
            REG_IVR:  w_rd              = w_ivr;
            REG_MER:  w_rd[0]           = r_mer;
            default:  w_rd              = 32'h0000_0000;
        endcase
    end

    assign o_rd_data = w_rd;
    assign o_irq     = r_irq;

    // State update; a new set beats a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_irq_q <= ZERO;
            r_isr   <= ZERO;
            r_ier   <= ZERO;
            r_mode  <= EDGE_DEFAULT;
            r_mer   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_irq_q <= i_irq;
            r_isr   <= (r_isr & ~w_w1c) | w_set;
            r_ier   <= w_ier_nxt;
            r_mode  <= w_mode_nxt;
            r_mer   <= w_mer_nxt;
            r_irq   <= r_mer & (|w_ipr);
        end
    end

endmodule

// File: rtl/irq_ctrl_axi.sv
// AXI4 slave front end for the interrupt controller: independent write and
// read FSMs around irq_ctrl_core. Bursts are answered with SLVERR.
module irq_ctrl_axi
    import irq_ctrl_pkg::*;
#(
    parameter int                 NUM_IRQ      = 8,
    parameter int                 ID_WIDTH     = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_DEFAULT = NUM_IRQ'(8'h01),
    parameter logic [31:0]        BASE_MASK    = 32'h0000_001F
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [NUM_IRQ-1:0]  irq_i,
    output logic                irq_o,
    input  logic [ID_WIDTH-1:0] s_aw_id,
    input  logic [31:0]         s_aw_addr,
    input  logic [7:0]          s_aw_len,
    input  logic                s_aw_valid,
    output logic                s_aw_ready,
    input  logic [31:0]         s_w_data,
    input  logic [3:0]          s_w_strb,
    input  logic                s_w_last,
    input  logic                s_w_valid,
    output logic                s_w_ready,
    output logic [ID_WIDTH-1:0] s_b_id,
    output logic [1:0]          s_b_resp,
    output logic                s_b_valid,
    input  logic                s_b_ready,
    input  logic [ID_WIDTH-1:0] s_ar_id,
    input  logic [31:0]         s_ar_addr,
    input  logic [7:0]          s_ar_len,
    input  logic                s_ar_valid,
    output logic                s_ar_ready,
    output logic [ID_WIDTH-1:0] s_r_id,
    output logic [31:0]         s_r_data,
    output logic [1:0]          s_r_resp,
    output logic                s_r_last,
    output logic                s_r_valid,
    input  logic                s_r_ready
);

    wr_state_e           r_wstate;
    logic                r_aw_ready, r_w_ready, r_b_valid;
    logic                r_have_aw, r_have_w;
    logic [ID_WIDTH-1:0] r_aw_id;
    logic [31:0]         r_aw_addr;
    logic [7:0]          r_aw_len;
    logic [31:0]         r_w_data;
    logic [3:0]          r_w_strb;
    logic                r_w_last;
    resp_t               r_b_resp;

    rd_state_e           r_rstate;
    logic                r_ar_ready, r_r_valid, r_r_last;
    logic [ID_WIDTH-1:0] r_r_id;
    logic [7:0]          r_r_len, r_r_beat;
    logic [31:0]         r_r_data;
    resp_t               r_r_resp;

    logic        w_aw_fire, w_w_fire, w_ar_fire, w_both, w_wr_en;
    logic [31:0] w_addr_eff, w_data_eff, w_aw_off, w_ar_off, w_rd_data;
    logic [7:0]  w_len_eff;
    logic [3:0]  w_strb_eff;
    logic        w_last_eff;
    logic        w_unused;

    assign w_aw_fire = s_aw_valid & r_aw_ready;
    assign w_w_fire  = s_w_valid & r_w_ready;
    assign w_ar_fire = s_ar_valid & r_ar_ready;

    // A half arriving this cycle is used directly, otherwise the latched copy.
    assign w_addr_eff = w_aw_fire ? s_aw_addr : r_aw_addr;
    assign w_len_eff  = w_aw_fire ? s_aw_len  : r_aw_len;
    assign w_data_eff = w_w_fire  ? s_w_data  : r_w_data;
    assign w_strb_eff = w_w_fire  ? s_w_strb  : r_w_strb;
    assign w_last_eff = w_w_fire  ? s_w_last  : r_w_last;
    assign w_both     = (r_have_aw | w_aw_fire) & (r_have_w | w_w_fire);
    assign w_wr_en    = w_both & (w_len_eff == 8'd0);
    assign w_aw_off   = w_addr_eff & BASE_MASK;
    assign w_ar_off   = s_ar_addr & BASE_MASK;
    assign w_unused   = ^{w_aw_off, w_ar_off};

    irq_ctrl_core #(
        .NUM_IRQ      (NUM_IRQ),
        .EDGE_DEFAULT (EDGE_DEFAULT)
    ) u_core (
        .i_clk     (aclk),
        .i_rst_n   (aresetn),
        .i_irq     (irq_i),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_aw_off[4:2]),
        .i_wr_data (w_data_eff),
        .i_wr_strb (w_strb_eff),
        .i_rd_idx  (w_ar_off[4:2]),
        .o_rd_data (w_rd_data),
        .o_irq     (irq_o)
    );

    assign s_aw_ready = r_aw_ready;
    assign s_w_ready  = r_w_ready;
    assign s_b_valid  = r_b_valid;
    assign s_b_id     = r_aw_id;
    assign s_b_resp   = r_b_resp;
    assign s_ar_ready = r_ar_ready;
    assign s_r_valid  = r_r_valid;
    assign s_r_last   = r_r_last;
    assign s_r_id     = r_r_id;
    assign s_r_data   = r_r_data;
    assign s_r_resp   = r_r_resp;

    // Write channel FSM: AW and W may arrive in either order or together.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wstate   <= W_IDLE;
            r_aw_ready <= 1'b1;
            r_w_ready  <= 1'b1;
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
            r_have_aw  <= 1'b0;
            r_have_w   <= 1'b0;
            r_aw_id    <= {ID_WIDTH{1'b0}};
            r_aw_addr  <= 32'h0000_0000;
            r_aw_len   <= 8'd0;
            r_w_data   <= 32'h0000_0000;
            r_w_strb   <= 4'h0;
            r_w_last   <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE, W_WAIT: begin
                    if (w_aw_fire) begin
                        r_aw_id   <= s_aw_id;
                        r_aw_addr <= s_aw_addr;
                        r_aw_len  <= s_aw_len;
                    end
                    if (w_w_fire) begin
                        r_w_data <= s_w_data;
                        r_w_strb <= s_w_strb;
                        r_w_last <= s_w_last;
                    end
                    if (w_both) begin
                        r_have_aw  <= 1'b0;
                        r_have_w   <= 1'b0;
                        r_aw_ready <= 1'b0;
                        if (w_len_eff == 8'd0) begin
                            r_wstate  <= W_RESP;
                            r_w_ready <= 1'b0;
                            r_b_valid <= 1'b1;
                            r_b_resp  <= RESP_OKAY;
                        end else if (w_last_eff) begin
                            r_wstate  <= W_RESP;
                            r_w_ready <= 1'b0;
                            r_b_valid <= 1'b1;
                            r_b_resp  <= RESP_SLVERR;
                        end else begin
                            r_wstate  <= W_BURST;
                            r_w_ready <= 1'b1;
                        end
                    end else if (w_aw_fire || w_w_fire) begin
                        r_wstate   <= W_WAIT;
                        r_have_aw  <= r_have_aw | w_aw_fire;
                        r_have_w   <= r_have_w | w_w_fire;
                        r_aw_ready <= ~(r_have_aw | w_aw_fire);
                        r_w_ready  <= ~(r_have_w | w_w_fire);
                    end
                end
                W_BURST: begin
                    if (w_w_fire && s_w_last) begin
                        r_wstate  <= W_RESP;
                        r_w_ready <= 1'b0;
                        r_b_valid <= 1'b1;
                        r_b_resp  <= RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (s_b_ready) begin
                        r_wstate   <= W_IDLE;
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_w_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_wstate   <= W_IDLE;
                    r_aw_ready <= 1'b1;
                    r_w_ready  <= 1'b1;
                    r_b_valid  <= 1'b0;
                    r_have_aw  <= 1'b0;
                    r_have_w   <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM: data is captured at AR accept and held until taken.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rstate   <= R_IDLE;
            r_ar_ready <= 1'b1;
            r_r_valid  <= 1'b0;
            r_r_last   <= 1'b0;
            r_r_id     <= {ID_WIDTH{1'b0}};
            r_r_len    <= 8'd0;
            r_r_beat   <= 8'd0;
            r_r_data   <= 32'h0000_0000;
            r_r_resp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_fire) begin
                        r_rstate   <= R_DATA;
                        r_ar_ready <= 1'b0;
                        r_r_valid  <= 1'b1;
                        r_r_id     <= s_ar_id;
                        r_r_len    <= s_ar_len;
                        r_r_beat   <= 8'd0;
                        r_r_last   <= (s_ar_len == 8'd0);
                        r_r_data   <= (s_ar_len == 8'd0) ? w_rd_data : 32'h0000_0000;
                        r_r_resp   <= (s_ar_len == 8'd0) ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (s_r_ready) begin
                        if (r_r_last) begin
                            r_rstate   <= R_IDLE;
                            r_r_valid  <= 1'b0;
                            r_r_last   <= 1'b0;
                            r_ar_ready <= 1'b1;
                        end else begin
                            r_r_beat <= r_r_beat + 8'd1;
                            r_r_last <= ((r_r_beat + 8'd1) == r_r_len);
                        end
                    end
                end
                default: begin
                    r_rstate   <= R_IDLE;
                    r_ar_ready <= 1'b1;
                    r_r_valid  <= 1'b0;
                    r_r_last   <= 1'b0;
                end
            endcase
        end
    end

endmodule
